codec_config_sequencer: RTL and testbench

Sequences the audio codec's register interface by driving the `i2c_controller` transaction port. After reset and a power-up delay, it walks an external init table of register writes. It then hands the I2C port to a host requester for runtime register reads and writes. It sits between the deck control logic and `i2c_controller`, and is the only master of that controller.

---
 rtl/codec_config_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_codec_config_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer
// Sole master of the i2c_controller transaction port. After reset it waits
// PWRUP_CYCLES, writes the external init table in order, and then serves
// single host register reads and writes. Every outstanding transaction is
// guarded by a TIMEOUT_CYCLES watchdog that sends the block to ERROR.
//
// Optional build macro: CODEC_READBACK_VERIFY_EN
//   When defined, each init write is read back and compared. On a mismatch
//   the write is retried, at most twice per entry.
`timescale 1ns/1ps

module codec_config_sequencer #(
    parameter int PWRUP_CYCLES   = 1000,
    parameter int INIT_LEN       = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  rom_index,
    input  logic [23:0] rom_entry,
    output logic        i2c_valid,
    output logic        i2c_rnw,
    output logic [15:0] i2c_address,
    output logic [7:0]  i2c_wdata,
    input  logic [7:0]  i2c_rdata,
    input  logic        i2c_done,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_rnw,
    input  logic [15:0] host_address,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        host_done,
    output logic        init_done,
    output logic        init_error
);

    // One counter serves both the power-up delay and the transaction watchdog.
    localparam int CNT_MAX    = (PWRUP_CYCLES > TIMEOUT_CYCLES) ? PWRUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int PWRUP_LAST = (PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] PWRUP_LAST_C = CNT_W'(PWRUP_LAST);
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       LAST_IDX     = 8'(INIT_LEN - 1);

    typedef enum logic [2:0] {
        PWRUP,
        INIT_ISSUE,
        INIT_WAIT,
`ifdef CODEC_READBACK_VERIFY_EN
        VERIFY_ISSUE,
        VERIFY_WAIT,
`endif
        IDLE,
        HOST_WAIT,
        ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       index_q, index_d;
    logic             i2c_valid_q, i2c_valid_d;
    logic             i2c_rnw_q, i2c_rnw_d;
    logic [15:0]      i2c_address_q, i2c_address_d;
    logic [7:0]       i2c_wdata_q, i2c_wdata_d;
    logic [7:0]       host_rdata_q, host_rdata_d;
    logic             host_done_q, host_done_d;
    logic             init_done_q, init_done_d;
    logic             init_error_q, init_error_d;
`ifdef CODEC_READBACK_VERIFY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    // The host may only issue a request from IDLE. Ready is also held low in
    // the cycle that reports the previous completion, so it stays low from
    // accept through host_done.
    assign host_ready  = (state_q == IDLE) && !host_done_q;

    assign rom_index   = index_q;
    assign i2c_valid   = i2c_valid_q;
    assign i2c_rnw     = i2c_rnw_q;
    assign i2c_address = i2c_address_q;
    assign i2c_wdata   = i2c_wdata_q;
    assign host_rdata  = host_rdata_q;
    assign host_done   = host_done_q;
    assign init_done   = init_done_q;
    assign init_error  = init_error_q;

    // Next-state, watchdog and transaction-field logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        index_d       = index_q;
        i2c_valid_d   = 1'b0;
        i2c_rnw_d     = i2c_rnw_q;
        i2c_address_d = i2c_address_q;
        i2c_wdata_d   = i2c_wdata_q;
        host_rdata_d  = 8'h00;
        host_done_d   = 1'b0;
        init_done_d   = init_done_q;
        init_error_d  = init_error_q;
`ifdef CODEC_READBACK_VERIFY_EN
        retry_d       = retry_q;
`endif

        case (state_q)
            PWRUP: begin
                if (cnt_q == PWRUP_LAST_C) begin
                    cnt_d   = '0;
                    index_d = 8'd0;
                    state_d = INIT_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            INIT_ISSUE: begin
                i2c_valid_d   = 1'b1;
                i2c_rnw_d     = 1'b0;
                i2c_address_d = rom_entry[23:8];
                i2c_wdata_d   = rom_entry[7:0];
                cnt_d         = '0;
                state_d       = INIT_WAIT;
            end

            INIT_WAIT: begin
                if (i2c_done) begin
`ifdef CODEC_READBACK_VERIFY_EN
                    state_d = VERIFY_ISSUE;
`else
                    if (index_q == LAST_IDX) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = INIT_ISSUE;
                    end
`endif
                end else if (cnt_q == TIMEOUT_C) begin
                    init_error_d = 1'b1;
                    state_d      = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef CODEC_READBACK_VERIFY_EN
            // Read back the address just written; wdata still holds the
            // table value and is the reference for the compare.
            VERIFY_ISSUE: begin
                i2c_valid_d = 1'b1;
                i2c_rnw_d   = 1'b1;
                cnt_d       = '0;
                state_d     = VERIFY_WAIT;
            end

            VERIFY_WAIT: begin
                if (i2c_done) begin
                    if (i2c_rdata == i2c_wdata_q) begin
                        retry_d = 2'd0;
                        if (index_q == LAST_IDX) begin
                            init_done_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            index_d = index_q + 8'd1;
                            state_d = INIT_ISSUE;
                        end
                    end else if (retry_q == 2'd2) begin
                        init_error_d = 1'b1;
                        state_d      = ERROR;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = INIT_ISSUE;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    init_error_d = 1'b1;
                    state_d      = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            IDLE: begin
                if (host_valid && host_ready) begin
                    i2c_valid_d   = 1'b1;
                    i2c_rnw_d     = host_rnw;
                    i2c_address_d = host_address;
                    i2c_wdata_d   = host_wdata;
                    cnt_d         = '0;
                    state_d       = HOST_WAIT;
                end
            end

            HOST_WAIT: begin
                if (i2c_done) begin
                    host_done_d  = 1'b1;
                    host_rdata_d = i2c_rnw_q ? i2c_rdata : 8'h00;
                    state_d      = IDLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    host_done_d  = 1'b1;
                    init_error_d = 1'b1;
                    state_d      = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ERROR: begin
                state_d = ERROR;
            end

            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PWRUP;
            cnt_q         <= '0;
            index_q       <= 8'd0;
            i2c_valid_q   <= 1'b0;
            i2c_rnw_q     <= 1'b0;
            i2c_address_q <= 16'h0000;
            i2c_wdata_q   <= 8'h00;
            host_rdata_q  <= 8'h00;
            host_done_q   <= 1'b0;
            init_done_q   <= 1'b0;
            init_error_q  <= 1'b0;
`ifdef CODEC_READBACK_VERIFY_EN
            retry_q       <= 2'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            index_q       <= index_d;
            i2c_valid_q   <= i2c_valid_d;
            i2c_rnw_q     <= i2c_rnw_d;
            i2c_address_q <= i2c_address_d;
            i2c_wdata_q   <= i2c_wdata_d;
            host_rdata_q  <= host_rdata_d;
            host_done_q   <= host_done_d;
            init_done_q   <= init_done_d;
            init_error_q  <= init_error_d;
`ifdef CODEC_READBACK_VERIFY_EN
            retry_q       <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer: three-entry init table, host
// read/write, early host request, watchdog edge cases, reset mid-init and,
// when CODEC_READBACK_VERIFY_EN is defined, read-back retry behaviour.
`timescale 1ns/1ps

module tb_codec_config_sequencer;

    localparam int P = 10;
    localparam int L = 3;
    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rom_index;
    logic [23:0] rom_entry;
    logic        i2c_valid;
    logic        i2c_rnw;
    logic [15:0] i2c_address;
    logic [7:0]  i2c_wdata;
    logic [7:0]  i2c_rdata;
    logic        i2c_done;
    logic        host_valid;
    logic        host_ready;
    logic        host_rnw;
    logic [15:0] host_address;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_done;
    logic        init_done;
    logic        init_error;

    int n_vec = 0;
    int n_err = 0;
    int n;
    int cnt;

    logic [23:0] rom [0:3] = '{24'h123412, 24'h0002A5, 24'h001000, 24'h000000};

    assign rom_entry = (rom_index[7:2] == 6'd0) ? rom[rom_index[1:0]] : 24'h000000;

    always #5 clk = ~clk;

    codec_config_sequencer #(
        .PWRUP_CYCLES  (P),
        .INIT_LEN      (L),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_index   (rom_index),
        .rom_entry   (rom_entry),
        .i2c_valid   (i2c_valid),
        .i2c_rnw     (i2c_rnw),
        .i2c_address (i2c_address),
        .i2c_wdata   (i2c_wdata),
        .i2c_rdata   (i2c_rdata),
        .i2c_done    (i2c_done),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_rnw    (host_rnw),
        .host_address(host_address),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_done   (host_done),
        .init_done   (init_done),
        .init_error  (init_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int cycles);
        cycles = 0;
        while (i2c_valid !== 1'b1 && cycles < max) begin
            step();
            cycles++;
        end
    endtask

    // Called just after the edge that raised i2c_valid; i2c_done is sampled
    // by the DUT exactly dly edges later.
    task automatic respond(input int dly, input logic [7:0] rd);
        step();
        chk("valid_pulse", i2c_valid, 0);
        chk("ready_busy", host_ready, 0);
        repeat (dly - 2) step();
        i2c_done  = 1'b1;
        i2c_rdata = rd;
        step();
        i2c_done  = 1'b0;
        i2c_rdata = 8'h00;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},  i2c_valid,   0);
        chk({tag, "_rnw"},    i2c_rnw,     0);
        chk({tag, "_addr"},   i2c_address, 0);
        chk({tag, "_wdata"},  i2c_wdata,   0);
        chk({tag, "_ready"},  host_ready,  0);
        chk({tag, "_hdone"},  host_done,   0);
        chk({tag, "_hrdata"}, host_rdata,  0);
        chk({tag, "_idone"},  init_done,   0);
        chk({tag, "_ierr"},   init_error,  0);
        chk({tag, "_index"},  rom_index,   0);
    endtask

    // Expects the write pulse for entry idx to be present now.
    task automatic init_entry(input int idx, input logic [15:0] a, input logic [7:0] d);
        int k;
        chk("init_rnw", i2c_rnw, 0);
        chk("init_addr", i2c_address, a);
        chk("init_wdata", i2c_wdata, d);
        chk("init_index", rom_index, idx);
        respond(50, 8'h00);
`ifdef CODEC_READBACK_VERIFY_EN
        wait_valid(5, k);
        chk("verify_lat", k, 1);
        chk("verify_rnw", i2c_rnw, 1);
        chk("verify_addr", i2c_address, a);
        respond(50, d);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        host_valid   = 1'b1;
        host_rnw     = 1'b1;
        host_address = 16'h0040;
        host_wdata   = 8'h00;
        i2c_done     = 1'b0;
        i2c_rdata    = 8'h00;
        repeat (3) step();
        chk_reset_vals("rst");

        // Init sequence with an early host request held since reset.
        rst = 1'b0;
        wait_valid(P + 20, n);
        chk("pwrup_lat", n, P + 1);
        init_entry(0, 16'h1234, 8'h12);
        wait_valid(5, n);
        chk("step_lat0", n, 1);
        chk("early_ready", host_ready, 0);
        chk("early_idone", init_done, 0);
        init_entry(1, 16'h0002, 8'hA5);
        wait_valid(5, n);
        chk("step_lat1", n, 1);
        init_entry(2, 16'h0010, 8'h00);
        chk("idone_set", init_done, 1);
        chk("no_err", init_error, 0);
        chk("idle_ready", host_ready, 1);
        chk("index_hold", rom_index, 2);

        // Early request accepted on the first IDLE cycle: host read 0x0040.
        step();
        host_valid = 1'b0;
        chk("hrd_valid", i2c_valid, 1);
        chk("hrd_rnw", i2c_rnw, 1);
        chk("hrd_addr", i2c_address, 16'h0040);
        chk("hrd_ready", host_ready, 0);
        respond(50, 8'h5A);
        chk("hrd_done", host_done, 1);
        chk("hrd_rdata", host_rdata, 8'h5A);
        chk("hrd_ready_done", host_ready, 0);
        step();
        chk("hrd_done_pulse", host_done, 0);
        chk("hrd_rdata_clr", host_rdata, 0);
        chk("hrd_ready_back", host_ready, 1);

        // Host write whose done lands on the timeout cycle: done wins.
        host_valid   = 1'b1;
        host_rnw     = 1'b0;
        host_address = 16'h0077;
        host_wdata   = 8'h3C;
        step();
        host_valid = 1'b0;
        chk("hwr_valid", i2c_valid, 1);
        chk("hwr_rnw", i2c_rnw, 0);
        chk("hwr_addr", i2c_address, 16'h0077);
        chk("hwr_wdata", i2c_wdata, 8'h3C);
        respond(T + 1, 8'hEE);
        chk("hwr_done", host_done, 1);
        chk("hwr_rdata", host_rdata, 0);
        chk("hwr_no_err", init_error, 0);
        step();

        // Late i2c_done while IDLE is ignored.
        i2c_done  = 1'b1;
        i2c_rdata = 8'h77;
        step();
        i2c_done  = 1'b0;
        i2c_rdata = 8'h00;
        chk("late_hdone", host_done, 0);
        chk("late_valid", i2c_valid, 0);
        chk("late_ready", host_ready, 1);

        // Host read that never completes: timeout pulses host_done with 0.
        host_valid   = 1'b1;
        host_rnw     = 1'b1;
        host_address = 16'h0099;
        step();
        host_valid = 1'b0;
        chk("hto_valid", i2c_valid, 1);
        repeat (T) step();
        chk("hto_early_done", host_done, 0);
        chk("hto_early_err", init_error, 0);
        step();
        chk("hto_done", host_done, 1);
        chk("hto_rdata", host_rdata, 0);
        chk("hto_err", init_error, 1);
        chk("hto_ready", host_ready, 0);

        // ERROR is absorbing, even with a host request and a stray done.
        host_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            i2c_done = (i == 3);
            step();
            if (i2c_valid === 1'b1) cnt++;
        end
        i2c_done = 1'b0;
        chk("err_valids", cnt, 0);
        chk("err_ready", host_ready, 0);
        chk("err_sticky", init_error, 1);
        host_valid = 1'b0;

        // Reset mid-init, during entry 2.
        rst = 1'b1;
        step();
        chk_reset_vals("rst2");
        rst = 1'b0;
        wait_valid(P + 20, n);
        chk("pwrup_lat2", n, P + 1);
        init_entry(0, 16'h1234, 8'h12);
        wait_valid(5, n);
        init_entry(1, 16'h0002, 8'hA5);
        wait_valid(5, n);
        chk("mid_index", rom_index, 2);
        repeat (20) step();
        rst = 1'b1;
        step();
        chk_reset_vals("rst3");
        rst = 1'b0;
        wait_valid(P + 20, n);
        chk("restart_lat", n, P + 1);
        chk("restart_index", rom_index, 0);
        chk("restart_addr", i2c_address, 16'h1234);

        // Timeout on entry 1 with the host still requesting.
        host_valid = 1'b1;
        init_entry(0, 16'h1234, 8'h12);
        wait_valid(5, n);
        chk("to_lat", n, 1);
        chk("to_index", rom_index, 1);
        repeat (T) step();
        chk("to_early_err", init_error, 0);
        step();
        chk("to_err", init_error, 1);
        chk("to_idone", init_done, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i2c_valid === 1'b1) cnt++;
        end
        chk("to_valids", cnt, 0);
        chk("to_ready", host_ready, 0);
        host_valid = 1'b0;

`ifdef CODEC_READBACK_VERIFY_EN
        // Entry 0 reads back 0x00 twice, then 0x12; entry 1 never matches.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_valid(P + 20, n);
        chk("v_pwrup", n, P + 1);
        for (int r = 0; r < 3; r++) begin
            chk("v0_wr_rnw", i2c_rnw, 0);
            chk("v0_wr_addr", i2c_address, 16'h1234);
            chk("v0_wr_index", rom_index, 0);
            respond(50, 8'h00);
            wait_valid(5, n);
            chk("v0_rd_lat", n, 1);
            chk("v0_rd_rnw", i2c_rnw, 1);
            respond(50, (r == 2) ? 8'h12 : 8'h00);
            wait_valid(5, n);
            chk("v0_next_lat", n, 1);
        end
        chk("v1_index", rom_index, 1);
        chk("v1_addr", i2c_address, 16'h0002);
        for (int r = 0; r < 3; r++) begin
            chk("v1_wr_rnw", i2c_rnw, 0);
            chk("v1_no_err", init_error, 0);
            respond(50, 8'h00);
            wait_valid(5, n);
            chk("v1_rd_rnw", i2c_rnw, 1);
            respond(50, 8'h00);
            if (r < 2) begin
                wait_valid(5, n);
                chk("v1_retry_lat", n, 1);
            end
        end
        chk("v1_err", init_error, 1);
        chk("v1_idone", init_done, 0);
        wait_valid(20, n);
        chk("v1_no_valid", n, 20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
